// File: rtl/sub_share_arbiter.sv
// -----------------------------------------------------------------------------
// sub_share_arbiter
//
// Round-robin arbiter and sequencer that time-shares one WIDTH-bit subtractor
// (difference plus borrow-out) between NREQ requesters. One operand pair is in
// flight at a time: IDLE grants and latches a request, EXEC performs A-B and
// registers the result, RESP holds the tagged result until it is consumed.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   WIDTH  operand/result width
//   IDW    requester index width, 2**IDW >= NREQ
//
// Ports:
//   iClk        clock, rising edge
//   iRst_n      asynchronous active-low reset
//   iReqValid   per-requester request valid
//   iReqA       minuends,    requester k at [k*WIDTH +: WIDTH]
//   iReqB       subtrahends, requester k at [k*WIDTH +: WIDTH]
//   oReqReady   one-hot grant/accept strobe (IDLE only)
//   oRspValid   response valid
//   oRspId      index of the requester owning the response
//   oRspDiff    A-B modulo 2**WIDTH
//   oRspBorrow  1 when A < B (unsigned)
//   oRspZero    (only with SUB_ARB_ZERO_FLAG_EN) 1 when the difference is 0
//   iRspReady   response consumer ready
//
// Build option:
//   SUB_ARB_ZERO_FLAG_EN  adds the oRspZero response flag.
// -----------------------------------------------------------------------------
module sub_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic [NREQ-1:0]       iReqValid,
    input  logic [NREQ*WIDTH-1:0] iReqA,
    input  logic [NREQ*WIDTH-1:0] iReqB,
    output logic [NREQ-1:0]       oReqReady,
    output logic                  oRspValid,
    output logic [IDW-1:0]        oRspId,
    output logic [WIDTH-1:0]      oRspDiff,
    output logic                  oRspBorrow,
`ifdef SUB_ARB_ZERO_FLAG_EN
    output logic                  oRspZero,
`endif
    input  logic                  iRspReady
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [IDW:0]     cand;
    logic [WIDTH:0]   sub_full;

    // Round-robin scan: start at rr_ptr and wrap by comparing against NREQ,
    // so non-power-of-two requester counts never visit a nonexistent index.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment would infer a latch.
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && iReqValid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    // Grant is combinational and only offered in IDLE. Gating with iRst_n keeps
    // the strobe low while reset is held even though valids may be present.
    always_comb begin
        oReqReady = '0;
        if (iRst_n && state == ST_IDLE && grant_found) begin
            oReqReady = NREQ'(1) << grant_id;
        end
    end

    // Extra MSB of the widened subtraction is the borrow-out (A < B).
    assign sub_full = {1'b0, op_a} - {1'b0, op_b};

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            op_id      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            oRspValid  <= 1'b0;
            oRspId     <= '0;
            oRspDiff   <= '0;
            oRspBorrow <= 1'b0;
`ifdef SUB_ARB_ZERO_FLAG_EN
            oRspZero   <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        op_a  <= iReqA[grant_id*WIDTH +: WIDTH];
                        op_b  <= iReqB[grant_id*WIDTH +: WIDTH];
                        op_id <= grant_id;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    oRspDiff   <= sub_full[WIDTH-1:0];
                    oRspBorrow <= sub_full[WIDTH];
`ifdef SUB_ARB_ZERO_FLAG_EN
                    oRspZero   <= (sub_full[WIDTH-1:0] == '0);
`endif
                    oRspId     <= op_id;
                    oRspValid  <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (iRspReady) begin
                        oRspValid <= 1'b0;
                        // Requester just served drops to lowest priority.
                        rr_ptr    <= (oRspId == IDW'(NREQ-1)) ? '0 : oRspId + IDW'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sub_share_arbiter
//
// Self-checking bench for sub_share_arbiter (NREQ=4, WIDTH=8, IDW=2): a table
// of single-request vectors, hand-written round-robin, backpressure and
// mid-operation reset sequences, and a randomized run against a transaction
// level reference model. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_sub_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_diff;
    logic                  rsp_borrow;
    logic                  rsp_ready;
`ifdef SUB_ARB_ZERO_FLAG_EN
    logic                  rsp_zero;
`endif

    int checks = 0;
    int errors = 0;

    sub_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iReqValid  (req_valid),
        .iReqA      (req_a),
        .iReqB      (req_b),
        .oReqReady  (req_ready),
        .oRspValid  (rsp_valid),
        .oRspId     (rsp_id),
        .oRspDiff   (rsp_diff),
        .oRspBorrow (rsp_borrow),
`ifdef SUB_ARB_ZERO_FLAG_EN
        .oRspZero   (rsp_zero),
`endif
        .iRspReady  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               port;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             zero;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int k);
        logic [NREQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic set_port(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[k*WIDTH +: WIDTH] = a;
        req_b[k*WIDTH +: WIDTH] = b;
    endtask

    // Waits (bounded) until a grant strobe shows up at a falling edge.
    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (req_ready == '0) check({name, "_grant_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready",  32'(req_ready),  32'd0);
        check("rst_valid",  32'(rsp_valid),  32'd0);
        check("rst_id",     32'(rsp_id),     32'd0);
        check("rst_diff",   32'(rsp_diff),   32'd0);
        check("rst_borrow", 32'(rsp_borrow), 32'd0);
`ifdef SUB_ARB_ZERO_FLAG_EN
        check("rst_zero",   32'(rsp_zero),   32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One isolated request; checks the accept cycle, the EXEC bubble, the
    // response two cycles after accept and its retirement.
    task automatic run_single(input vec_t v);
        set_port(v.port, v.a, v.b);
        req_valid = onehot(v.port);
        rsp_ready = 1'b1;
        #1;
        wait_grant("single");
        check("single_ready", 32'(req_ready), 32'(onehot(v.port)));
        @(negedge clk);
        req_valid = '0;
        #1;
        check("single_exec_valid", 32'(rsp_valid), 32'd0);
        check("single_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("single_rsp_valid",  32'(rsp_valid),  32'd1);
        check("single_rsp_id",     32'(rsp_id),     32'(v.port));
        check("single_rsp_diff",   32'(rsp_diff),   32'(v.diff));
        check("single_rsp_borrow", 32'(rsp_borrow), 32'(v.borrow));
`ifdef SUB_ARB_ZERO_FLAG_EN
        check("single_rsp_zero",   32'(rsp_zero),   32'(v.zero));
`endif
        @(negedge clk);
        #1;
        check("single_done_valid", 32'(rsp_valid), 32'd0);
    endtask

    // ---------------- randomized run with reference model ----------------
    task automatic random_run(input int cycles);
        bit               pending [NREQ];
        logic [WIDTH-1:0] pa [NREQ];
        logic [WIDTH-1:0] pb [NREQ];
        int               ptr;
        bit               busy;
        int               wait_cnt;
        int               e_id;
        logic [WIDTH-1:0] e_diff;
        logic             e_borrow;
        int               g;
        logic [NREQ-1:0]  e_ready;
        int               k;

        for (int i = 0; i < NREQ; i++) pending[i] = 1'b0;
        ptr = 0; busy = 1'b0; wait_cnt = 0;
        e_id = 0; e_diff = '0; e_borrow = 1'b0;

        for (int c = 0; c < cycles; c++) begin
            // New requests appear only on idle requester lanes; pending ones
            // hold valid and operands until granted.
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 3) == 0) begin
                    pending[i] = 1'b1;
                    pa[i] = WIDTH'($urandom);
                    pb[i] = WIDTH'($urandom);
                    set_port(i, pa[i], pb[i]);
                end
                req_valid[i] = pending[i];
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;

            g = -1;
            if (!busy) begin
                for (int i = 0; i < NREQ; i++) begin
                    k = (ptr + i) % NREQ;
                    if (g < 0 && pending[k]) g = k;
                end
            end
            e_ready = (g >= 0) ? onehot(g) : '0;
            check("rnd_ready", 32'(req_ready), 32'(e_ready));
            check("rnd_valid", 32'(rsp_valid), 32'(busy && wait_cnt == 0));
            if (busy && wait_cnt == 0) begin
                check("rnd_id",     32'(rsp_id),     32'(e_id));
                check("rnd_diff",   32'(rsp_diff),   32'(e_diff));
                check("rnd_borrow", 32'(rsp_borrow), 32'(e_borrow));
            end

            // Advance the model across the coming rising edge.
            if (g >= 0) begin
                busy       = 1'b1;
                wait_cnt   = 1;
                e_id       = g;
                e_diff     = pa[g] - pb[g];
                e_borrow   = (pa[g] < pb[g]);
                pending[g] = 1'b0;
                ptr        = (g + 1) % NREQ;
            end else if (busy) begin
                if (wait_cnt > 0) wait_cnt--;
                else if (rsp_ready) busy = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] d_hold;
        logic [WIDTH-1:0] a_k;
        logic [WIDTH-1:0] b_k;
        logic [WIDTH-1:0] d_k;

        vecs[0] = '{port: 2, a: 8'h35, b: 8'h12, diff: 8'h23, borrow: 1'b0, zero: 1'b0};
        vecs[1] = '{port: 0, a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1, zero: 1'b0};
        vecs[2] = '{port: 0, a: 8'h7F, b: 8'h7F, diff: 8'h00, borrow: 1'b0, zero: 1'b1};
        vecs[3] = '{port: 3, a: 8'hFF, b: 8'h00, diff: 8'hFF, borrow: 1'b0, zero: 1'b0};
        vecs[4] = '{port: 1, a: 8'h10, b: 8'h20, diff: 8'hF0, borrow: 1'b1, zero: 1'b0};
        vecs[5] = '{port: 2, a: 8'h80, b: 8'h7F, diff: 8'h01, borrow: 1'b0, zero: 1'b0};
        vecs[6] = '{port: 3, a: 8'h00, b: 8'hFF, diff: 8'h01, borrow: 1'b1, zero: 1'b0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        do_reset();

        // --- table-driven single requests ---
        for (int i = 0; i < 7; i++) run_single(vecs[i]);

        // --- all ports valid: grants 0,1,2,3,0,1 three cycles apart ---
        do_reset();
        for (int k = 0; k < NREQ; k++) set_port(k, WIDTH'(8'h40 + 8'h11 * k), WIDTH'(8'h13 * k));
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        wait_grant("rr");
        for (int n = 0; n < 6; n++) begin
            a_k = WIDTH'(8'h40 + 8'h11 * (n % NREQ));
            b_k = WIDTH'(8'h13 * (n % NREQ));
            d_k = a_k - b_k;
            check("rr_grant", 32'(req_ready), 32'(onehot(n % NREQ)));
            @(negedge clk);
            #1;
            check("rr_exec_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            #1;
            check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rr_rsp_id",    32'(rsp_id),    32'(n % NREQ));
            check("rr_rsp_diff",  32'(rsp_diff),  32'(d_k));
            @(negedge clk);
            #1;
        end
        req_valid = '0;
        repeat (4) @(negedge clk);

        // --- response backpressure with port 1 waiting ---
        do_reset();
        set_port(0, 8'h9A, 8'h1B);
        set_port(1, 8'h05, 8'h03);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        wait_grant("bp");
        check("bp_grant0", 32'(req_ready), 32'(4'b0001));
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        #1;
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        d_hold = rsp_diff;
        check("bp_rsp_diff", 32'(rsp_diff), 32'(8'h7F));
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_id",    32'(rsp_id),    32'd0);
            check("bp_hold_diff",  32'(rsp_diff),  32'(d_hold));
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_after_valid", 32'(rsp_valid), 32'd0);
        check("bp_grant1",      32'(req_ready), 32'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("bp_rsp1_id",   32'(rsp_id),   32'd1);
        check("bp_rsp1_diff", 32'(rsp_diff), 32'd2);
        repeat (2) @(negedge clk);

        // --- reset during RESP aborts and restores rr_ptr to 0 ---
        run_single('{port: 0, a: 8'h01, b: 8'h01, diff: 8'h00, borrow: 1'b0, zero: 1'b1});
        set_port(2, 8'h50, 8'h10);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        wait_grant("rst");
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("rst_mid_valid_before", 32'(rsp_valid), 32'd1);
        check("rst_mid_diff_before",  32'(rsp_diff),  32'(8'h40));
        set_port(3, 8'h22, 8'h11);
        set_port(0, 8'h44, 8'h04);
        rst_n     = 1'b0;
        req_valid = 4'b1001;
        #1;
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_diff",  32'(rsp_diff),  32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("rst_first_grant", 32'(req_ready), 32'(4'b0001));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("rst_first_id",   32'(rsp_id),   32'd0);
        check("rst_first_diff", 32'(rsp_diff), 32'(8'h40));
        repeat (2) @(negedge clk);

        // --- randomized traffic against the reference model ---
        do_reset();
        random_run(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
